risc_v_fetch_unit: RTL

- Parametrised instruction-fetch front end for the next-generation RISC-V core.
- Replaces the core's single-cycle PC register and combinational instruction read.
- Issues pipelined requests to a variable-latency instruction memory over a valid/ready handshake.
- Buffers returned words in a prefetch FIFO, presents {pc, instr} to decode, and handles redirects (branch/jump/trap) by flushing and discarding in-flight responses.

---
 rtl/risc_v_pkg.sv | 13 +
 rtl/risc_v_fetch_unit_if.sv | 34 +++
 rtl/risc_v_fetch_unit_fifo.sv | 43 ++++
 rtl/risc_v_fetch_unit.sv | 106 ++++++++++
 4 files changed

// File: rtl/risc_v_pkg.sv
// rtl/risc_v_pkg.sv - shared constants and fetch entry type for the RISC-V fetch front end
package risc_v_pkg;
   localparam int INSTR_WIDTH = 32;
   localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam int DEFAULT_WORD_LENGTH = 32;

   typedef struct packed {
      logic [DEFAULT_WORD_LENGTH-1:0] pc;
      logic [INSTR_WIDTH-1:0]         instr;
      logic                           misaligned;
   } fetch_entry_t;
endpackage

// File: rtl/risc_v_fetch_unit_if.sv
// rtl/risc_v_fetch_unit_if.sv - imem, redirect and decode-side signals of the fetch unit
// FETCH_MISALIGN_TRAP_EN adds instr_misaligned.
interface risc_v_fetch_unit_if #(parameter int WORD_LENGTH = 32);
   logic                   imem_req_valid;
   logic                   imem_req_ready;
   logic [WORD_LENGTH-1:0] imem_req_addr;
   logic                   imem_rsp_valid;
   logic [31:0]            imem_rsp_data;
   logic                   redirect_valid;
   logic [WORD_LENGTH-1:0] redirect_pc;
   logic                   instr_valid;
   logic                   instr_ready;
   logic [31:0]            instr_data;
   logic [WORD_LENGTH-1:0] instr_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic                   instr_misaligned;
`endif

   modport master (
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, instr_ready,
`ifdef FETCH_MISALIGN_TRAP_EN
      output instr_misaligned,
`endif
      output imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc
   );

   modport slave (
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, instr_ready,
`ifdef FETCH_MISALIGN_TRAP_EN
      input  instr_misaligned,
`endif
      input  imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc
   );
endinterface

// File: rtl/risc_v_fetch_unit_fifo.sv
// rtl/risc_v_fetch_unit_fifo.sv - registered prefetch FIFO; flush overrides push and pop
module fetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush,
   input  logic                         push,
   input  logic [WIDTH-1:0]             push_data,
   input  logic                         pop,
   output logic [WIDTH-1:0]             pop_data,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         empty,
   output logic                         full
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;

   assign pop_data = mem[rd_ptr];
   assign empty    = (count == '0);
   assign full     = (count == CNT_W'(DEPTH));

   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= push_data;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end
endmodule

// File: rtl/risc_v_fetch_unit.sv
// rtl/risc_v_fetch_unit.sv - pipelined instruction fetch with prefetch FIFO and redirect flush
// FETCH_MISALIGN_TRAP_EN turns a misaligned redirect into a single NOP trap entry.
module risc_v_fetch_unit
   import risc_v_pkg::*;
#(
   parameter int WORD_LENGTH = 32,
   parameter int FIFO_DEPTH  = 4,
   parameter logic [WORD_LENGTH-1:0] RESET_PC = WORD_LENGTH'(DEFAULT_RESET_PC)
) (
   input logic                 clk,
   input logic                 reset,
   risc_v_fetch_unit_if.master bus
);
   localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
   localparam int ENTRY_W = WORD_LENGTH + INSTR_WIDTH;
   localparam logic [WORD_LENGTH-1:0] PC_STEP    = WORD_LENGTH'(4);
   localparam logic [WORD_LENGTH-1:0] ALIGN_MASK = ~WORD_LENGTH'(3);

   logic [WORD_LENGTH-1:0] fetch_pc, rsp_pc, redirect_base;
   logic [CNT_W-1:0]       outstanding, discard, fifo_count, in_flight;
   logic                   fifo_empty, fifo_full, credit_ok, req_fire, rsp_keep;
   logic                   fifo_pop, out_valid, out_fire, fetch_halt;
   logic [ENTRY_W-1:0]     push_entry, head_entry;

   assign redirect_base = bus.redirect_pc & ALIGN_MASK;
   assign credit_ok = !fifo_full &&
      (((CNT_W+1)'(fifo_count) + (CNT_W+1)'(outstanding)) < (CNT_W+1)'(FIFO_DEPTH));

   assign bus.imem_req_valid = !reset && !bus.redirect_valid && credit_ok && !fetch_halt;
   assign bus.imem_req_addr  = fetch_pc & ALIGN_MASK;
   assign req_fire   = bus.imem_req_valid && bus.imem_req_ready;
   assign rsp_keep   = bus.imem_rsp_valid && !bus.redirect_valid && (discard == '0);
   assign in_flight  = outstanding - CNT_W'(bus.imem_rsp_valid);
   assign push_entry = {rsp_pc, bus.imem_rsp_data};

`ifdef FETCH_MISALIGN_TRAP_EN
   logic                   trap_hold, trap_valid;
   logic [WORD_LENGTH-1:0] trap_pc;

   assign fetch_halt           = trap_hold;
   assign out_valid            = !fifo_empty || trap_valid;
   assign bus.instr_pc         = trap_valid ? trap_pc : head_entry[ENTRY_W-1 -: WORD_LENGTH];
   assign bus.instr_data       = trap_valid ? NOP_INSTR : head_entry[INSTR_WIDTH-1:0];
   assign bus.instr_misaligned = !reset && trap_valid;

   // The trap entry bypasses the FIFO so it is visible the cycle after the redirect.
   always_ff @(posedge clk) begin
      if (reset) begin
         trap_hold  <= 1'b0;
         trap_valid <= 1'b0;
         trap_pc    <= '0;
      end else if (bus.redirect_valid) begin
         trap_hold  <= |bus.redirect_pc[1:0];
         trap_valid <= |bus.redirect_pc[1:0];
         trap_pc    <= bus.redirect_pc;
      end else if (out_fire) begin
         trap_valid <= 1'b0;
      end
   end
`else
   assign fetch_halt     = 1'b0;
   assign out_valid      = !fifo_empty;
   assign bus.instr_pc   = head_entry[ENTRY_W-1 -: WORD_LENGTH];
   assign bus.instr_data = head_entry[INSTR_WIDTH-1:0];
`endif

   assign bus.instr_valid = !reset && !bus.redirect_valid && out_valid;
   assign out_fire        = bus.instr_valid && bus.instr_ready;
   assign fifo_pop        = out_fire && !fifo_empty;

   // Every response still in flight at a redirect belongs to the old stream.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc    <= RESET_PC;
         rsp_pc      <= RESET_PC;
         outstanding <= '0;
         discard     <= '0;
      end else if (bus.redirect_valid) begin
         fetch_pc    <= redirect_base;
         rsp_pc      <= redirect_base;
         outstanding <= in_flight;
         discard     <= in_flight;
      end else begin
         if (req_fire) fetch_pc <= fetch_pc + PC_STEP;
         if (rsp_keep) rsp_pc   <= rsp_pc + PC_STEP;
         outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(bus.imem_rsp_valid);
         if (bus.imem_rsp_valid && (discard != '0)) discard <= discard - CNT_W'(1);
      end
   end

   fetch_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (bus.redirect_valid),
      .push      (rsp_keep),
      .push_data (push_entry),
      .pop       (fifo_pop),
      .pop_data  (head_entry),
      .count     (fifo_count),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );
endmodule
